// File: rtl/fourphase_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fourphase_tx_ctrl_pkg
// Description : Shared definitions for the four-phase crossing endpoints.
//               Holds the handshake FSM state encoding and the default
//               datapath dimensions. The rx-side counterpart imports the
//               same package so both ends agree on the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fourphase_tx_ctrl_pkg;

  // Default datapath dimensions
  localparam int unsigned C_DEF_DATA_WIDTH = 8;
  localparam int unsigned C_DEF_DEPTH      = 4;
  localparam int unsigned C_DEF_ADDR_W     = 2;

  // Handshake FSM states, fixed encoding shared with the rx side
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } tx_state_t;

endpackage : fourphase_tx_ctrl_pkg
`default_nettype wire

// File: rtl/fourphase_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : fourphase_tx_ctrl_if
// Description : Core-side write port, status and crossing-side req/ack/data
//               of the four-phase transmit endpoint.
//   in_data  core word, sampled when v=1 and f=0
//   v        core valid
//   f        FIFO full
//   d        one-cycle word-completed pulse
//   req_out  four-phase request towards the rx domain
//   data_out word on the crossing, stable while req_out=1
//   ack_in   acknowledge from the rx domain (asynchronous)
//   modport master : core + rx side (drives in_data, v, ack_in)
//   modport slave  : transmit endpoint
// Revision    : 1.0 - initial release
// ============================================================================
interface fourphase_tx_ctrl_if
  import fourphase_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = C_DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  v;
  logic                  f;
  logic                  d;
  logic                  req_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack_in;

  modport master (
    output in_data,
    output v,
    output ack_in,
    input  f,
    input  d,
    input  req_out,
    input  data_out
  );

  modport slave (
    input  in_data,
    input  v,
    input  ack_in,
    output f,
    output d,
    output req_out,
    output data_out
  );

endinterface : fourphase_tx_ctrl_if
`default_nettype wire

// File: rtl/fourphase_tx_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : fourphase_tx_ctrl_sync_2ff
// Description : 1-bit two-flop synchroniser with asynchronous reset to 0.
//               Brings a level from a foreign clock domain into clk.
//               Reusable by the rx-side endpoint for req.
//   clk      destination clock, rising edge
//   rst      asynchronous, active-high
//   i_async  level from the foreign domain
//   o_sync   synchronised level (two clk edges of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module fourphase_tx_ctrl_sync_2ff (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_async,
  output logic      o_sync
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; only the second flop is used downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : fourphase_tx_ctrl_sync_2ff
`default_nettype wire

// File: rtl/fourphase_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fourphase_tx_ctrl
// Description : Transmit endpoint of a two-flop four-phase clock-domain
//               crossing. Buffers core words in a small FIFO and sends each
//               as a req/ack handshake with data held stable while req is
//               high. ack_in is synchronised through two flops.
//   clk_tx   single clock, rising edge
//   reset    asynchronous, active-high, clears all state
//   bus      fourphase_tx_ctrl_if.slave (in_data, v, f, d, req_out,
//            data_out, ack_in)
// Revision    : 1.0 - initial release
// ============================================================================
module fourphase_tx_ctrl
  import fourphase_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = C_DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = C_DEF_DEPTH,
  parameter int unsigned ADDR_W     = C_DEF_ADDR_W
) (
  input  wire logic           clk_tx,
  input  wire logic           reset,
  fourphase_tx_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;

  // Handshake FSM and its registered outputs
  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic                  r_req;
  logic                  w_req_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;

  logic                  w_ack_s;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;

  fourphase_tx_ctrl_sync_2ff u_ack_sync (
    .clk     (clk_tx),
    .rst     (reset),
    .i_async (bus.ack_in),
    .o_sync  (w_ack_s)
  );

  assign w_full = (r_count == C_FULL);
  // A write while full is silently dropped
  assign w_push = bus.v && !w_full;

  // Storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk_tx) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk_tx or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      // Simultaneous push and pop leave the count unchanged
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_tx or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_done  <= w_done_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // The pop reads the registered count, so a word pushed on this edge is
  // only seen by IDLE on the following edge. An early ack_s in IDLE/SETUP
  // is ignored; WAIT_HI then leaves on it immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_done_nxt  = 1'b0;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_req_nxt = 1'b0;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_data_nxt  = r_mem[r_rd_ptr];
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // data_out has been stable for a full cycle before req rises
        w_req_nxt   = 1'b1;
        w_state_nxt = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!w_ack_s) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.f        = w_full;
  assign bus.d        = r_done;
  assign bus.req_out  = r_req;
  assign bus.data_out = r_data;

endmodule : fourphase_tx_ctrl
`default_nettype wire

// File: tb/tb_fourphase_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fourphase_tx_ctrl
// Description : Self-checking bench for fourphase_tx_ctrl. An rx-side
//               responder answers req with configurable random delay; a
//               monitor records every word at the rising edge of req and
//               counts d pulses. Expected words come from a plain queue of
//               accepted writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fourphase_tx_ctrl;

  logic clk_tx = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_tx = ~clk_tx;

  fourphase_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  logic ack_auto   = 1'b0;
  logic ack_glitch = 1'b0;
  assign bus.ack_in = ack_auto | ack_glitch;

  fourphase_tx_ctrl #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .ADDR_W     (2)
  ) dut (
    .clk_tx (clk_tx),
    .reset  (reset),
    .bus    (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         d_cnt   = 0;
  logic [7:0] obs[$];
  logic       resp_en      = 1'b0;
  int         resp_dly_max = 0;

  typedef struct {
    logic       v;
    logic [7:0] din;
    logic       f;
    logic       req;
    logic [7:0] dout;
    logic       d;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Main thread acts 2 ns after each edge: monitor at +1, responder at +3
  task automatic tick();
    @(posedge clk_tx);
    #2;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.v    = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    obs.delete();
    d_cnt    = 0;
  endtask

  task automatic push_word(input logic [7:0] w);
    int budget;
    budget = 200;
    while (bus.f && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("push wait for f=0", 32'(bus.f), 32'd0);
    bus.v       = 1'b1;
    bus.in_data = w;
    tick();
    bus.v       = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, input string name);
    while ((obs.size() < n || d_cnt < n) && budget > 0) begin
      tick();
      budget--;
    end
    check({name, " words seen"}, 32'(obs.size()), 32'(n));
    check({name, " d pulses"}, 32'(d_cnt), 32'(n));
  endtask

  // rx-side responder: follows req with 0..resp_dly_max extra cycles
  initial begin : responder
    int cnt;
    int dly;
    cnt = 0;
    dly = 0;
    forever begin
      @(posedge clk_tx);
      #3;
      if (!resp_en) begin
        ack_auto = 1'b0;
        cnt      = 0;
      end else if (bus.req_out != ack_auto) begin
        if (cnt >= dly) begin
          ack_auto = bus.req_out;
          cnt      = 0;
          dly      = $urandom_range(0, resp_dly_max);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: log words at req rise, count d, check data_out holds until d
  initial begin : monitor
    logic       prev_req;
    logic       busy;
    logic [7:0] cur;
    prev_req = 1'b0;
    busy     = 1'b0;
    cur      = '0;
    forever begin
      @(posedge clk_tx);
      #1;
      if (reset) begin
        prev_req = 1'b0;
        busy     = 1'b0;
      end else begin
        if (bus.req_out && !prev_req) begin
          obs.push_back(bus.data_out);
          busy = 1'b1;
          cur  = bus.data_out;
        end else if (busy) begin
          check("data_out stable in handshake", 32'(bus.data_out), 32'(cur));
        end
        if (bus.d) begin
          d_cnt++;
          busy = 1'b0;
        end
        prev_req = bus.req_out;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] exp_q[$];
    logic [7:0] w;
    int         budget;

    // One word is popped onto the crossing, so full needs five writes
    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h01, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0};

    // ---- 1: reset held with v=1 ----
    bus.v       = 1'b1;
    bus.in_data = 8'h77;
    tick();
    tick();
    check("t1 f in reset", 32'(bus.f), 32'd0);
    check("t1 d in reset", 32'(bus.d), 32'd0);
    check("t1 req in reset", 32'(bus.req_out), 32'd0);
    check("t1 data in reset", 32'(bus.data_out), 32'd0);
    bus.v = 1'b0;
    reset = 1'b0;
    repeat (4) tick();
    check("t1 req after release", 32'(bus.req_out), 32'd0);
    check("t1 nothing stored", 32'(dut.r_count), 32'd0);

    // ---- 2: single word A5, exact cycle timing ----
    obs.delete();
    d_cnt        = 0;
    resp_en      = 1'b1;
    resp_dly_max = 0;
    bus.v        = 1'b1;
    bus.in_data  = 8'hA5;
    tick();  // edge N
    bus.v = 1'b0;
    check("t2 req at N", 32'(bus.req_out), 32'd0);
    tick();  // N+1
    check("t2 data at N+1", 32'(bus.data_out), 32'hA5);
    check("t2 req at N+1", 32'(bus.req_out), 32'd0);
    tick();  // N+2
    check("t2 req at N+2", 32'(bus.req_out), 32'd1);
    tick();
    tick();  // N+4
    check("t2 req at N+4", 32'(bus.req_out), 32'd1);
    tick();  // N+5
    check("t2 req at N+5", 32'(bus.req_out), 32'd0);
    tick();
    tick();  // N+7
    check("t2 d at N+7", 32'(bus.d), 32'd0);
    tick();  // N+8
    check("t2 d at N+8", 32'(bus.d), 32'd1);
    tick();
    check("t2 d at N+9", 32'(bus.d), 32'd0);
    repeat (5) tick();
    wait_obs(1, 10, "t2");
    if (obs.size() >= 1) check("t2 word", 32'(obs[0]), 32'hA5);

    // ---- 3: fill to full with ack stalled (table-driven) ----
    resp_en = 1'b0;
    do_reset();
    foreach (tbl[i]) begin
      bus.v       = tbl[i].v;
      bus.in_data = tbl[i].din;
      tick();
      check($sformatf("t3 row%0d f", i), 32'(bus.f), 32'(tbl[i].f));
      check($sformatf("t3 row%0d req", i), 32'(bus.req_out), 32'(tbl[i].req));
      check($sformatf("t3 row%0d data", i), 32'(bus.data_out), 32'(tbl[i].dout));
      check($sformatf("t3 row%0d d", i), 32'(bus.d), 32'(tbl[i].d));
    end
    bus.v   = 1'b0;
    resp_en = 1'b1;
    wait_obs(5, 200, "t3");
    for (int i = 0; i < 5 && i < obs.size(); i++)
      check($sformatf("t3 order %0d", i), 32'(obs[i]), 32'(i + 1));

    // ---- 4: same-cycle push and pop at count=2, then 10 words with wrap ----
    resp_en = 1'b0;
    do_reset();
    push_word(8'h41);
    push_word(8'h42);
    push_word(8'h43);
    tick();
    check("t4 count before", 32'(dut.r_count), 32'd2);
    resp_en = 1'b1;
    budget  = 50;
    while (!bus.d && budget > 0) begin
      tick();
      budget--;
    end
    check("t4 d seen", 32'(bus.d), 32'd1);
    bus.v       = 1'b1;
    bus.in_data = 8'h44;
    tick();
    bus.v       = 1'b0;
    check("t4 count push+pop", 32'(dut.r_count), 32'd2);
    check("t4 popped word", 32'(bus.data_out), 32'h42);
    for (int i = 5; i <= 10; i++) push_word(8'(8'h40 + i));
    wait_obs(10, 400, "t4");
    for (int i = 0; i < 10 && i < obs.size(); i++)
      check($sformatf("t4 order %0d", i), 32'(obs[i]), 32'(8'h41 + i));

    // ---- 5: reset in WAIT_HI with 3 words queued ----
    resp_en = 1'b0;
    do_reset();
    push_word(8'h10);
    push_word(8'h11);
    push_word(8'h12);
    push_word(8'h13);
    tick();
    tick();
    check("t5 req before reset", 32'(bus.req_out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5 req on reset", 32'(bus.req_out), 32'd0);
    check("t5 f on reset", 32'(bus.f), 32'd0);
    check("t5 data on reset", 32'(bus.data_out), 32'd0);
    check("t5 count on reset", 32'(dut.r_count), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    check("t5 no d pulse", 32'(d_cnt), 32'd0);
    obs.delete();
    d_cnt   = 0;
    resp_en = 1'b1;
    push_word(8'h35);
    wait_obs(1, 50, "t5");
    if (obs.size() >= 1) check("t5 word", 32'(obs[0]), 32'h35);

    // ---- 6: sub-period ack glitch in IDLE ----
    resp_en = 1'b1;
    do_reset();
    #5;
    ack_glitch = 1'b1;
    @(posedge clk_tx);
    #3;
    ack_glitch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6 req c%0d", i), 32'(bus.req_out), 32'd0);
      check($sformatf("t6 d c%0d", i), 32'(bus.d), 32'd0);
    end
    check("t6 count", 32'(dut.r_count), 32'd0);
    check("t6 data", 32'(bus.data_out), 32'd0);
    push_word(8'h5A);
    wait_obs(1, 50, "t6");
    if (obs.size() >= 1) check("t6 word", 32'(obs[0]), 32'h5A);

    // ---- random traffic against a queue model ----
    resp_en      = 1'b1;
    resp_dly_max = 3;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (!bus.f && $urandom_range(0, 1) == 1) begin
        w           = 8'($urandom_range(0, 255));
        bus.v       = 1'b1;
        bus.in_data = w;
        exp_q.push_back(w);
      end else if (bus.f && $urandom_range(0, 3) == 0) begin
        bus.v       = 1'b1;           // write while full: must be dropped
        bus.in_data = 8'hEE;
      end else begin
        bus.v = 1'b0;
      end
      tick();
    end
    bus.v = 1'b0;
    wait_obs(exp_q.size(), 5000, "rand");
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("rand word %0d", i), 32'(obs[i]), 32'(exp_q[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fourphase_tx_ctrl
`default_nettype wire
